hex_uart_tx: RTL and testbench
==============================

# hex_uart_tx

Serial result streamer for the calculator board. It takes a 64-bit word (the same 64-bit value selected for the 7-segment display) and sends it to a host terminal over a UART line. The format is 16 uppercase ASCII hex characters, most-significant nibble first, optionally followed by CR LF. It is the board-to-host counterpart of the button/switch operand-entry path and sits beside the display mux in the top level. A transmission is triggered by a one-cycle `start` pulse, e.g. a debounced button pulse.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000, input clock frequency in Hz.
- `BAUD`, default 115200, line rate.
  - Derived `CLKS_PER_BIT = CLK_HZ / BAUD`, integer truncation; 434 at the defaults.
  - Must be ≥ 2.

Ports:
- `clk`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  request pulse; sampled every cycle.
- `data`  in  64  word to send; sampled only in the cycle `start` is accepted.
- `tx`  out  1  UART line, 8N1, idle high.
- `busy`  out  1  high from the cycle after acceptance until the message ends.
- `done`  out  1  one-cycle pulse at message end.

## Operation
- Reset values: `tx=1`, `busy=0`, `done=0`, state IDLE, all counters 0.
- Acceptance: `start` is accepted in any cycle where `busy==0`, including the cycle `done` is high. `start` while `busy==1` is ignored and not queued.
- On acceptance, `data` is latched into a 64-bit shift register and the character index is cleared.
- Character order: nibble [63:60] first, [3:0] last.
- Nibble-to-ASCII mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46 (uppercase).
- Each byte is framed as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is exactly `CLKS_PER_BIT` cycles.
- Bytes are sent back-to-back, with no idle gap between the stop bit and the next start bit.
- State machine:
  - IDLE → START on accept.
  - START → DATA after 1 bit time.
  - DATA → STOP after 8 bit times.
  - STOP → START if bytes remain, else → IDLE with the `done` pulse.
- Message length is 18 bytes with CRLF enabled, 16 bytes without.
- Reset mid-operation: the cycle after `rst` is seen high, all reset values apply. The partial frame is abandoned and `done` does not pulse.

## Timing
- `start` accepted in cycle N → `tx` goes low and `busy` goes high in cycle N+1. Both are registered outputs.
- Bit k of byte j begins at cycle N+1+(10·j+k)·`CLKS_PER_BIT`.
- `done=1` and `busy=0` in cycle N+1+10·B·`CLKS_PER_BIT`, where B = 16 or 18.
  - Defaults with CRLF: 78 120 cycles ≈ 1.56 ms.
- Back-to-back: `start` held high continuously starts the next message in the `done` cycle. That message's start bit appears the following cycle.
- `data` changes after acceptance have no effect on the message in flight.

## Configuration
- Macro `HEX_UART_TX_CRLF_EN`.
- Defined: after the 16 hex characters, send 0x0D then 0x0A (B = 18).
- Undefined: the message ends after the 16th hex character (B = 16). The CR/LF logic and the extra index states are not compiled in.

## Structure
Shared package `hex_uart_tx_pkg` holds:
- the state enum (IDLE, START, DATA, STOP);
- constants `CHAR_CR=8'h0D`, `CHAR_LF=8'h0A`, `MSG_HEX_CHARS=16`;
- the nibble-to-ASCII function.

One sub-module, `uart_byte_tx`:
- 8N1 serializer with the baud counter.
- Byte-valid/ready handshake; it accepts the next byte in its last stop-bit cycle, which allows back-to-back bytes.
- `hex_uart_tx` itself is the character sequencer around it.

## Test plan
All scenarios use `CLK_HZ=16`, `BAUD=1` (`CLKS_PER_BIT=16`) with CRLF enabled, unless noted.

1. Reset: hold `rst` for 3 cycles, then release → `tx=1`, `busy=0`, `done=0`. Idle for 100 cycles → no change.
2. Full message: `start` pulse with `data=64'h0123456789ABCDEF` → UART monitor decodes "0123456789ABCDEF\r\n". `done` pulses exactly 2881 cycles after the accept cycle.
3. Busy ignore: second `start` with `data=64'hFFFF...` at cycle 500 of a message → output is unchanged and there is exactly one `done` pulse.
4. Reset mid-frame: assert `rst` during byte 5, DATA state → `tx=1` the next cycle and no `done`. A following `start` with `64'h0` → "0000000000000000\r\n".
5. Back-to-back: `start` held high with `data=64'hA5A5A5A5A5A5A5A5` → two identical messages. The second start bit begins 1 cycle after the first `done`.
6. Macro undefined, `data=64'hDEADBEEF00000001` → "DEADBEEF00000001" with no CR/LF. `done` arrives 2561 cycles after accept.

Source files
------------

// File: rtl/hex_uart_tx_pkg.sv
// hex_uart_tx_pkg: shared state enum, character constants and nibble-to-ASCII helper
package hex_uart_tx_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam int MSG_HEX_CHARS = 16;
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serializer; takes the next byte in its last stop-bit cycle
import hex_uart_tx_pkg::*;
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic tx_q, tx_d;
  logic bit_end;
  assign bit_end = cnt_q == CNT_LAST;
  assign byte_ready = state_q == IDLE || (state_q == STOP && bit_end);
  assign tx = tx_q;
  // frame sequencing: start bit, eight data bits LSB first, stop bit; a new byte overrides
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    tx_d = tx_q;
    case (state_q)
      START: if (bit_end) begin
        state_d = DATA;
        bit_d = '0;
        tx_d = sh_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          tx_d = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d = sh_q >> 1;
          tx_d = sh_q[1];
        end
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        tx_d = 1'b1;
      end
      default: ;
    endcase
    if (byte_valid && byte_ready) begin
      state_d = START;
      cnt_d = '0;
      sh_d = byte_data;
      tx_d = 1'b0;
    end
  end
  // serializer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: rtl/hex_uart_tx.sv
// hex_uart_tx: streams a 64-bit word as 16 hex chars over UART; HEX_UART_TX_CRLF_EN appends CR LF
import hex_uart_tx_pkg::*;
module hex_uart_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
`ifdef HEX_UART_TX_CRLF_EN
  localparam logic [4:0] MSG_BYTES = 5'(MSG_HEX_CHARS + 2);
`else
  localparam logic [4:0] MSG_BYTES = 5'(MSG_HEX_CHARS);
`endif
  logic busy_q, busy_d, done_q, done_d;
  logic [63:0] sr_q, sr_d;
  logic [4:0] idx_q, idx_d;
  logic byte_valid, byte_ready;
  logic [7:0] byte_data;
  assign busy = busy_q;
  assign done = done_q;
  // the first character is handed over in the accept cycle straight from data, so the
  // register holds the remaining nibbles and the index already counts that character
  always_comb begin
    byte_valid = busy_q ? idx_q != MSG_BYTES : start;
`ifdef HEX_UART_TX_CRLF_EN
    byte_data = (busy_q && idx_q == 5'(MSG_HEX_CHARS)) ? CHAR_CR :
                (busy_q && idx_q == 5'(MSG_HEX_CHARS + 1)) ? CHAR_LF :
                nibble_to_ascii(busy_q ? sr_q[63:60] : data[63:60]);
`else
    byte_data = nibble_to_ascii(busy_q ? sr_q[63:60] : data[63:60]);
`endif
    sr_d = sr_q;
    idx_d = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (!busy_q && start) begin
      sr_d = {data[59:0], 4'h0};
      idx_d = 5'd1;
      busy_d = 1'b1;
    end else if (busy_q && byte_ready) begin
      if (byte_valid) begin
        sr_d = {sr_q[59:0], 4'h0};
        idx_d = idx_q + 5'd1;
      end else begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end
  // sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sr_q <= '0;
      idx_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      sr_q <= sr_d;
      idx_q <= idx_d;
    end
  end
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
    .clk(clk),
    .rst(rst),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .tx(tx)
  );
endmodule

// File: tb/tb_hex_uart_tx.sv
// tb_hex_uart_tx: directed table-driven bench for hex_uart_tx at 16 clocks per bit
module tb_hex_uart_tx;
  localparam int C = 16;
  typedef struct {
    logic [63:0] d;
    string s;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [63:0] data = '0;
  logic tx, busy, done;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  string tail;
  vec_t v[5];

  hex_uart_tx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // accept one message, decode every frame at mid-bit and check the done timing;
  // poke>0 raises a stray start with all-ones data at that cycle offset
  task automatic send(input logic [63:0] d, input string exp, input bit hold, input int poke);
    int t;
    int target;
    int b;
    logic [9:0] fr;
    b = exp.len();
    data = d;
    start = 1'b1;
    tick();
    start = hold;
    t = 1;
    chk("start_bit_first_cycle", {tx, busy}, 2'b01);
    for (int j = 0; j < b; j++) begin
      for (int k = 0; k < 10; k++) begin
        target = 1 + (10 * j + k) * C + C / 2;
        while (t < target) begin
          if (t == poke) begin
            start = 1'b1;
            data = '1;
          end
          tick();
          t++;
          if (t == poke + 1) start = hold;
        end
        fr[k] = tx;
      end
      chk($sformatf("frame%0d", j), fr, {1'b1, exp[j], 1'b0});
    end
    while (t < 10 * b * C) begin
      tick();
      t++;
    end
    chk("pre_done", {done, busy}, 2'b01);
    tick();
    chk("done_cycle", {done, busy}, 2'b10);
  endtask

  initial begin
    int d0;
`ifdef HEX_UART_TX_CRLF_EN
    tail = "\r\n";
`else
    tail = "";
`endif
    v[0] = '{64'h0123456789ABCDEF, "0123456789ABCDEF"};
    v[1] = '{64'hFEDCBA9876543210, "FEDCBA9876543210"};
    v[2] = '{64'h0000000000000000, "0000000000000000"};
    v[3] = '{64'hDEADBEEF00000001, "DEADBEEF00000001"};
    v[4] = '{64'hA5A5A5A5A5A5A5A5, "A5A5A5A5A5A5A5A5"};
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_state", {tx, busy, done}, 3'b100);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_hold", {tx, busy, done}, 3'b100);
    end
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      send(v[i].d, {v[i].s, tail}, 1'b0, 0);
      tick();
      chk("done_single_pulse", done_cnt - d0, 1);
      chk("after_done_idle", {tx, busy, done}, 3'b100);
    end
    d0 = done_cnt;
    send(v[0].d, {v[0].s, tail}, 1'b0, 500);
    repeat (40) tick();
    chk("busy_ignore_one_done", done_cnt - d0, 1);
    chk("busy_ignore_idle", {tx, busy}, 2'b10);
    data = 64'h123456789ABCDEF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (53 * C + C / 2) tick();
    chk("mid_frame_busy", busy, 1'b1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    chk("mid_frame_reset", {tx, busy, done}, 3'b100);
    rst = 1'b0;
    repeat (3000) tick();
    chk("no_done_after_abort", done_cnt - d0, 0);
    chk("idle_after_abort", {tx, busy}, 2'b10);
    send(64'h0, {"0000000000000000", tail}, 1'b0, 0);
    tick();
    d0 = done_cnt;
    send(v[4].d, {v[4].s, tail}, 1'b1, 0);
    send(v[4].d, {v[4].s, tail}, 1'b0, 0);
    tick();
    chk("back_to_back_dones", done_cnt - d0, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
